// File: rtl/gated_clock_v2_axil_regs_pkg.sv
// Shared types and constants for the gated-clock control register file.
package gated_clock_v2_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CFG0 = 2'd1;
    localparam logic [1:0] REG_CFG1 = 2'd2;
    localparam logic [1:0] REG_CFG2 = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef logic [3:0][31:0] reg_bank_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_VALID
    } rd_state_t;

endpackage

// File: rtl/gated_clock_v2_axil_regs_if.sv
// AXI4-Lite control bus between the system master and the register file.
interface gated_clock_v2_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
        input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );

endinterface

// File: rtl/gated_clock_v2_axil_regs_strb_merge.sv
// Byte-wise merge of a new word into an old one under a byte-enable mask.
module gated_clock_v2_strb_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    // Replace only the enabled bytes.
    always_comb begin
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

endmodule

// File: rtl/gated_clock_v2_axil_regs.sv
// AXI4-Lite register file: four R/W words exported to the gated-clock core.
//
// write FSM
//   state      | meaning
//   WR_IDLE    | both holders empty, AW and W accepted
//   WR_HAVE_AW | address held, waiting for data
//   WR_HAVE_W  | data held, waiting for address
//   WR_RESP    | write committed, BVALID high until BREADY
// read FSM
//   RD_IDLE    | ARREADY high
//   RD_VALID   | RDATA/RVALID held until RREADY
module gated_clock_v2_axil_regs
    import gated_clock_v2_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    gated_clock_v2_axil_regs_if.slave   s_axi,
    output reg_bank_t                   reg_out,
    output logic [3:0]                  reg_wr_pulse
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic [1:0]                    wr_idx;
    logic [31:0]                   merged;
    logic                          aw_rdy, w_rdy, aw_hs, w_hs, commit;
    logic                          ar_rdy, ar_hs;
    logic [31:0]                   rdata_q;
    logic                          unused_bits;

    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // A holder being filled in the same cycle is bypassed so commit needs no extra cycle.
    assign wr_addr = (wr_state == WR_HAVE_AW) ? aw_addr_q : s_axi.S_AXI_AWADDR;
    assign wr_data = (wr_state == WR_HAVE_W)  ? w_data_q  : s_axi.S_AXI_WDATA;
    assign wr_strb = (wr_state == WR_HAVE_W)  ? w_strb_q  : s_axi.S_AXI_WSTRB;
    assign wr_idx  = wr_addr[3:2];

    gated_clock_v2_strb_merge u_merge (
        .old_word (reg_out[wr_idx]),
        .wdata    (wr_data),
        .wstrb    (wr_strb),
        .merged   (merged)
    );

    // Write FSM next state, ready generation and commit decision.
    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        aw_rdy  = !ARESET && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
        w_rdy   = !ARESET && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
        aw_hs   = s_axi.S_AXI_AWVALID && aw_rdy;
        w_hs    = s_axi.S_AXI_WVALID && w_rdy;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: if (w_hs) begin
                commit  = 1'b1;
                wr_next = WR_RESP;
            end
            WR_HAVE_W: if (aw_hs) begin
                commit  = 1'b1;
                wr_next = WR_RESP;
            end
            WR_RESP: if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write state, holders, register bank and write pulses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state     <= WR_IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            reg_out      <= '0;
            reg_wr_pulse <= '0;
        end else begin
            wr_state     <= wr_next;
            reg_wr_pulse <= '0;
            if (aw_hs) aw_addr_q <= s_axi.S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= s_axi.S_AXI_WDATA;
                w_strb_q <= s_axi.S_AXI_WSTRB;
            end
            if (commit) begin
                reg_out[wr_idx]      <= merged;
                reg_wr_pulse[wr_idx] <= 1'b1;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        rd_next = rd_state;
        ar_rdy  = !ARESET && (rd_state == RD_IDLE);
        ar_hs   = s_axi.S_AXI_ARVALID && ar_rdy;
        case (rd_state)
            RD_IDLE:  if (ar_hs) rd_next = RD_VALID;
            RD_VALID: if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
            default:  rd_next = RD_IDLE;
        endcase
    end

    // Read state and data capture; the bank is sampled before any same-edge write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) rdata_q <= reg_out[s_axi.S_AXI_ARADDR[3:2]];
        end
    end

    assign s_axi.S_AXI_AWREADY = aw_rdy;
    assign s_axi.S_AXI_WREADY  = w_rdy;
    assign s_axi.S_AXI_BVALID  = (wr_state == WR_RESP);
    assign s_axi.S_AXI_BRESP   = AXI_RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = ar_rdy;
    assign s_axi.S_AXI_RVALID  = (rd_state == RD_VALID);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_gated_clock_v2_axil_regs.sv
// Directed bench for the gated-clock AXI4-Lite register file.
module tb_gated_clock_v2_axil_regs;
    import gated_clock_v2_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESET;
    reg_bank_t  reg_out;
    logic [3:0] reg_wr_pulse;
    int         n_pass  = 0;
    int         n_total = 0;

    gated_clock_v2_axil_regs_if axi ();

    gated_clock_v2_axil_regs dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .s_axi        (axi),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr_start(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
    endtask

    task automatic wr_wait_accept(input string tag);
        logic aw_go, w_go;
        for (int i = 0; i < 20; i++) begin
            aw_go = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_go  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(negedge ACLK);
            if (aw_go) axi.S_AXI_AWVALID = 1'b0;
            if (w_go)  axi.S_AXI_WVALID  = 1'b0;
            if (!axi.S_AXI_AWVALID && !axi.S_AXI_WVALID) break;
        end
        chk({tag, "_accept"}, {axi.S_AXI_AWVALID, axi.S_AXI_WVALID}, 2'b00);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
    endtask

    task automatic wr_resp(input string tag, input bit chk_pulse, input logic [3:0] exp_pulse);
        for (int i = 0; i < 20; i++) begin
            if (axi.S_AXI_BVALID) break;
            @(negedge ACLK);
        end
        chk({tag, "_bvalid"}, axi.S_AXI_BVALID, 1'b1);
        chk({tag, "_bresp"}, axi.S_AXI_BRESP, 2'b00);
        if (chk_pulse) chk({tag, "_pulse"}, reg_wr_pulse, exp_pulse);
        axi.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_BREADY = 1'b0;
        chk({tag, "_bvalid_clr"}, axi.S_AXI_BVALID, 1'b0);
        chk({tag, "_pulse_clr"}, reg_wr_pulse, 4'b0000);
    endtask

    task automatic do_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << addr[3:2];
        wr_start(addr, data, strb);
        wr_wait_accept(tag);
        wr_resp(tag, 1'b1, one_hot);
    endtask

    task automatic do_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic go;
        logic got;
        got = 1'b0;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            go = axi.S_AXI_ARREADY;
            @(negedge ACLK);
            if (go) begin
                got = 1'b1;
                break;
            end
        end
        axi.S_AXI_ARVALID = 1'b0;
        chk({tag, "_ar_accept"}, got, 1'b1);
        chk({tag, "_rvalid"}, axi.S_AXI_RVALID, 1'b1);
        chk({tag, "_rdata"}, axi.S_AXI_RDATA, exp);
        chk({tag, "_rresp"}, axi.S_AXI_RRESP, 2'b00);
        axi.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        ARESET            = 1'b1;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWPROT  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARPROT  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;

        // reset
        repeat (3) @(negedge ACLK);
        chk("rst_readies", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b000);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_valids", {axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 2'b00);
        chk("rst_regs", reg_out, 128'h0);
        chk("rst_pulse", reg_wr_pulse, 4'b0000);
        chk("rst_rdata", axi.S_AXI_RDATA, 32'h0);
        chk("idle_readies", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);

        // basic writes and read back
        do_write("wr0", 4'h0, 32'h1, 4'hF);
        do_write("wr1", 4'h4, 32'h2, 4'hF);
        do_write("wr2", 4'h8, 32'h3, 4'hF);
        do_write("wr3", 4'hC, 32'h4, 4'hF);
        chk("bank_after_wr", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
        do_read("rd0", 4'h0, 32'h1);
        do_read("rd1", 4'h4, 32'h2);
        do_read("rd2", 4'h8, 32'h3);
        do_read("rd3", 4'hC, 32'h4);
        do_read("rd_alias", 4'h7, 32'h2);

        // W arrives three cycles before AW
        axi.S_AXI_WDATA  = 32'hDEADBEEF;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_WVALID = 1'b0;
        ok = 1'b1;
        repeat (2) begin
            ok &= !axi.S_AXI_BVALID && !axi.S_AXI_WREADY && axi.S_AXI_AWREADY;
            @(negedge ACLK);
        end
        chk("wfirst_wait", ok, 1'b1);
        axi.S_AXI_AWADDR  = 4'h4;
        axi.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        chk("wfirst_bvalid_next", axi.S_AXI_BVALID, 1'b1);
        wr_resp("wfirst", 1'b1, 4'b0010);
        chk("wfirst_reg1", reg_out[1], 32'hDEADBEEF);

        // byte strobes and empty strobe
        do_write("strb_base", 4'h8, 32'h11223344, 4'hF);
        do_write("strb_0101", 4'h8, 32'hAABBCCDD, 4'b0101);
        chk("strb_reg2", reg_out[2], 32'h11BB33DD);
        do_write("strb_none", 4'h8, 32'hFFFFFFFF, 4'b0000);
        chk("strb_none_reg2", reg_out[2], 32'h11BB33DD);

        // BREADY held low blocks a second write
        wr_start(4'h0, 32'h77, 4'hF);
        wr_wait_accept("bp1");
        chk("bp1_pulse", reg_wr_pulse, 4'b0001);
        wr_start(4'h0, 32'h99, 4'hF);
        ok = 1'b1;
        repeat (10) begin
            ok &= axi.S_AXI_BVALID && !axi.S_AXI_AWREADY && !axi.S_AXI_WREADY;
            @(negedge ACLK);
        end
        chk("bp_hold", ok, 1'b1);
        chk("bp_reg0_first", reg_out[0], 32'h77);
        wr_resp("bp1", 1'b0, 4'b0000);
        wr_wait_accept("bp2");
        wr_resp("bp2", 1'b1, 4'b0001);
        chk("bp_reg0_second", reg_out[0], 32'h99);

        // read and write commit to 0xC in the same cycle
        axi.S_AXI_ARADDR  = 4'hC;
        axi.S_AXI_ARVALID = 1'b1;
        wr_start(4'hC, 32'h55, 4'hF);
        chk("same_readies", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        chk("same_valids", {axi.S_AXI_RVALID, axi.S_AXI_BVALID}, 2'b11);
        chk("same_rdata_old", axi.S_AXI_RDATA, 32'h4);
        chk("same_pulse", reg_wr_pulse, 4'b1000);
        chk("same_reg3", reg_out[3], 32'h55);
        axi.S_AXI_RREADY = 1'b1;
        axi.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_RREADY = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        chk("same_done", {axi.S_AXI_RVALID, axi.S_AXI_BVALID}, 2'b00);
        do_read("same_reread", 4'hC, 32'h55);

        // reset with a read response pending and the AW holder full
        axi.S_AXI_ARADDR  = 4'h0;
        axi.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
        chk("mid_rvalid", axi.S_AXI_RVALID, 1'b1);
        axi.S_AXI_AWADDR  = 4'h4;
        axi.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("mid_rst_rvalid", axi.S_AXI_RVALID, 1'b0);
        chk("mid_rst_bvalid", axi.S_AXI_BVALID, 1'b0);
        chk("mid_rst_regs", reg_out, 128'h0);
        chk("mid_rst_awready", axi.S_AXI_AWREADY, 1'b0);
        ARESET = 1'b0;
        axi.S_AXI_WDATA  = 32'h123;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_WVALID = 1'b0;
        chk("post_rst_no_commit", {axi.S_AXI_BVALID, reg_wr_pulse}, 5'b00000);
        do_read("post_rst_rd0", 4'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gated_clock_v2_axil_regs.md
Name: gated_clock_v2_axil_regs

Overview:
AXI4-Lite slave register file that terminates the control bus driven by the system master (VIP/BFM master in simulation, PS in hardware).
Holds four 32-bit read/write registers, exports them to the gated-clock core, and emits per-register write strobes.
Sits directly downstream of the AXI4-Lite master and directly upstream of the gated-clock core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; ADDR[3:2] selects the register, ADDR[1:0] is ignored.

Ports:
ACLK  in  1  single clock for the whole block.
ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  4  write address.
S_AXI_AWPROT  in  3  accepted and ignored.
S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write data handshake.
S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response handshake.
S_AXI_ARADDR  in  4  read address.
S_AXI_ARPROT  in  3  accepted and ignored.
S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00 (OKAY).
S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data handshake.
reg_out  out  4x32  current register contents, index 0..3.
reg_wr_pulse  out  4  one-cycle pulse per register, asserted in the cycle after a committed write.

Behaviour:
- Reset (ARESET=1 at a posedge):
  - All registers, RDATA, BVALID, RVALID and reg_wr_pulse go to 0.
  - AWREADY, WREADY and ARREADY are held 0 while ARESET=1.
  - Any in-flight transaction is discarded; no response is issued for it.
- Write channel:
  - AW and W are captured independently into holding registers; they may arrive in either order or in the same cycle.
  - AWREADY=1 when the AW holding register is empty, BVALID=0 and not in reset. WREADY follows the same rule on the W holding register.
  - Commit occurs in the cycle where both holders are full and BVALID=0. On commit:
    - reg[ADDR[3:2]] is updated byte-wise under WSTRB.
    - Both holders are cleared.
    - BVALID=1 and reg_wr_pulse[idx]=1 on the next edge; the pulse lasts exactly one cycle.
  - Minimum latency: AW and W accepted in cycle N, BVALID high in cycle N+1.
  - BVALID holds until BREADY. No new AW or W is accepted while BVALID=1, so at most one write is outstanding.
  - WSTRB=0 still commits, returns OKAY and fires reg_wr_pulse; register contents are unchanged.
- Read channel:
  - ARREADY = !RVALID && !ARESET.
  - On an AR handshake in cycle N, RDATA = reg[ARADDR[3:2]] and RVALID=1 in cycle N+1.
  - RDATA and RVALID are held stable until RREADY.
- Simultaneous read handshake and write commit to the same register: the read returns the pre-write value.
- Read and write channels are fully independent; both may complete in the same cycle.
- Address wrap: any address aliases modulo 16 bytes. There is no decode error and the response is always OKAY.

Decomposition:
- Shared package gated_clock_v2_pkg holds:
  - REG_CTRL=0, REG_CFG0=1, REG_CFG1=2, REG_CFG2=3 index constants.
  - AXI_RESP_OKAY=2'b00.
  - Typedef reg_bank_t as a 4-entry array of 32-bit words, used for reg_out.
- One sub-module, gated_clock_v2_strb_merge: combinational byte-wise merge of old word, WDATA and WSTRB. It is reused by the core's shadow registers.
- Write FSM and read FSM both live in the top module.

Test Plan:
- Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1,0x2,0x3,0x4, all BRESP/RRESP=OKAY, reg_wr_pulse fires bits 0,1,2,3 in order.
- W presented 3 cycles before AW (addr 0x4, data 0xDEADBEEF) -> exactly one commit, one cycle after AW is accepted; reg_out[1]=0xDEADBEEF.
- Write 0xAABBCCDD with WSTRB=4'b0101 over 0x11223344 at 0x8 -> reg_out[2]=0x11BB33DD.
- BREADY held low for 10 cycles -> BVALID stays 1, AWREADY/WREADY stay 0, a second AW waits; it completes after BREADY is asserted.
- Read 0xC in the same cycle a write of 0x55 to 0xC commits (old value 0x4) -> RDATA=0x4, then a subsequent read returns 0x55.
- ARESET asserted while RVALID=1 and the AW holder is full -> next cycle RVALID=0, all reg_out=0, no BVALID. Post-reset read of 0x0 returns 0.
